serial_link_arbiter: RTL and testbench
======================================

# serial_link_arbiter

Round-robin scheduler that shares one serial link among `n_req` parallel requesters. It accepts a `width`-bit word from the granted requester and shifts it out LSB-first on `serial_valid`/`serial_data`, directly driving a `serial_to_parallel` deserializer of the same `width`. It then inserts a programmable idle gap before granting again, which guarantees frame separation on the link.

## Interface
- `width`, 8: bits per frame; must be ≥ 2.
- `n_req`, 4: number of requesters; must be ≥ 2.
- `gap`, 1: idle cycles forced after each frame; 0 is allowed.
- `clk`  in  1  clock; all activity on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `n_req`  bit i high: requester i holds a word.
- `req_data`  in  `n_req*width`  word of requester i at `[i*width +: width]`.
- `req_ready`  out  `n_req`  one-hot acceptance strobe.
- `serial_valid`  out  1  the link carries a data bit this cycle.
- `serial_data`  out  1  the link bit.
- `frame_done`  out  1  high in the cycle of the last bit of a frame.
- `busy`  out  1  state is not IDLE.
- `grant_id`  out  `$clog2(n_req)`  index of the requester owning the current or last frame.

## Operation
- FSM states:
  - IDLE → SHIFT when any `req_valid` is high.
  - SHIFT → GAP after bit `width-1` when `gap` > 0.
  - SHIFT → IDLE after bit `width-1` when `gap` = 0.
  - GAP → IDLE after `gap` cycles.
- Arbitration:
  - Round-robin pointer `last`. Search starts at `last+1` mod `n_req`; the first requester with `req_valid` high wins.
  - After reset `last` = `n_req-1`, so requester 0 has top priority first.
  - `last` updates to the winner on acceptance only.
- Acceptance:
  - `req_ready` is combinational: it is asserted for the winner only, only in IDLE, only while that requester's `req_valid` is high.
  - Transfer occurs at the edge where `req_valid[i] & req_ready[i]`.
  - On that edge the word is latched into the shift register, `grant_id` is set to i, and the FSM enters SHIFT.
  - A requester must hold `req_data` stable while `req_valid` is high and not yet accepted.
  - `req_valid` may drop without acceptance; no transfer occurs.
- Shifting:
  - Bit k of the word is on `serial_data` during the k-th SHIFT cycle (k = 0..`width-1`), LSB-first.
  - `serial_valid` is 1 throughout SHIFT and 0 otherwise.
  - `serial_data` is 0 whenever `serial_valid` is 0.
  - The bit counter runs 0..`width-1` and needs `$clog2(width)` bits; it is cleared on entry to SHIFT.
- `frame_done` = `serial_valid` & (counter == `width-1`).
- `req_valid` changes during SHIFT/GAP have no effect. Arbitration is re-evaluated in the first IDLE cycle.
- Reset:
  - Asserting `rst` low at any time aborts immediately.
  - A partially shifted frame is dropped and not resumed; no retransmit.
  - The requester of a dropped frame is not notified.

## Timing
- Reset values:
  - `serial_valid`=0, `serial_data`=0, `frame_done`=0, `busy`=0, `grant_id`=0, `req_ready`=0.
  - FSM = IDLE, `last` = `n_req-1`, counter = 0.
- All outputs except `req_ready` are registered.
- Latency:
  - Acceptance edge at cycle t.
  - Bit 0 appears in cycle t+1; the last bit and `frame_done` appear in cycle t+`width`.
  - GAP occupies cycles t+`width`+1 .. t+`width`+`gap`.
  - The next acceptance is possible in cycle t+`width`+`gap`+1.
- Sustained throughput: one frame per `width`+`gap`+1 cycles. There is always at least one idle link cycle between frames, even with `gap`=0.
- `busy` is high from t+1 through the last GAP cycle.

## Test plan
- Reset, then a single request: `req_valid`=0001 with word 8'hA5. `req_ready[0]` pulses for 1 cycle. The next 8 cycles carry `serial_valid`=1 and data 1,0,1,0,0,1,0,1. `frame_done` is high on the 8th. `grant_id`=0. A deserializer on the link reports 8'hA5.
- All four requesters valid continuously with words 8'h01, 8'h02, 8'h04, 8'h08, `gap`=1:
  - Grants occur in order 0,1,2,3,0.
  - Frames start every 10 cycles.
  - Each `req_ready` is one-hot.
- Fairness wrap: after granting 2, only requesters 0 and 3 are valid. 3 is granted before 0.
- `gap`=0 back-to-back, one requester held valid: exactly one cycle with `serial_valid`=0 between frames.
- Assert `rst` low during bit 3 of a frame:
  - `serial_valid` and `busy` drop immediately.
  - After release, requester 0 has priority.
  - The next frame starts from bit 0 with the newly accepted word.
- `req_valid` withdrawn in IDLE before the edge: no `req_ready`, no frame, `last` unchanged.

Source files
------------

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter sharing one LSB-first serial link among n_req requesters,
// with a programmable idle gap after every frame.
module serial_link_arbiter #(
    parameter int width = 8,
    parameter int n_req = 4,
    parameter int gap   = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [n_req-1:0]               req_valid_i,
    input  logic [n_req*width-1:0]         req_data_i,
    output logic [n_req-1:0]               req_ready_o,
    output logic                           serial_valid_o,
    output logic                           serial_data_o,
    output logic                           frame_done_o,
    output logic                           busy_o,
    output logic [$clog2(n_req)-1:0]       grant_id_o,
    output logic [1:0]                     state_o
);

    localparam int iw = $clog2(n_req);
    localparam int cw = $clog2(width);
    localparam int gw = (gap > 1) ? $clog2(gap) : 1;

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_shift = 2'd1;
    localparam logic [1:0] st_gap   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [iw-1:0]    last_q, last_d;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic [gw-1:0]    gcnt_q, gcnt_d;
    logic [width-1:0] sh_q, sh_d;
    logic [iw-1:0]    gid_q, gid_d;
    logic             sv_q, sv_d;
    logic             sd_q, sd_d;
    logic             fd_q, fd_d;
    logic             busy_q, busy_d;

    logic [width-1:0] words [n_req];
    logic [iw-1:0]    cand;
    logic [iw-1:0]    win;
    logic             found;
    logic             accept;

    for (genvar g = 0; g < n_req; g++) begin : g_unpack
        assign words[g] = req_data_i[g*width +: width];
    end

    // Search begins one past the last winner, so the previous owner ranks lowest.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= n_req; k++) begin
            cand = iw'((int'(last_q) + k) % n_req);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Handshake: req_ready is offered only in IDLE to the current winner while its
    // req_valid is high; a word transfers on the edge where both are high, and a
    // requester may withdraw req_valid before that edge without any side effect.
    assign accept = (state_q == st_idle) && found;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        sh_d    = sh_q;
        gid_d   = gid_q;
        case (state_q)
            st_idle: begin
                if (accept) begin
                    state_d = st_shift;
                    last_d  = win;
                    gid_d   = win;
                    sh_d    = words[win];
                    cnt_d   = '0;
                end
            end
            st_shift: begin
                if (cnt_q == cw'(width - 1)) begin
                    if (gap > 0) begin
                        state_d = st_gap;
                        gcnt_d  = '0;
                    end else begin
                        state_d = st_idle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sh_d  = sh_q >> 1;
                end
            end
            st_gap: begin
                if (int'(gcnt_q) + 1 >= gap) begin
                    state_d = st_idle;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Link outputs are decoded from next-state so they are registered yet aligned.
    always_comb begin
        sv_d   = (state_d == st_shift);
        sd_d   = sv_d & sh_d[0];
        fd_d   = sv_d && (cnt_d == cw'(width - 1));
        busy_d = (state_d != st_idle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= st_idle;
            last_q  <= iw'(n_req - 1);
            cnt_q   <= '0;
            gcnt_q  <= '0;
            sh_q    <= '0;
            gid_q   <= '0;
            sv_q    <= 1'b0;
            sd_q    <= 1'b0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            sh_q    <= sh_d;
            gid_q   <= gid_d;
            sv_q    <= sv_d;
            sd_q    <= sd_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
        end
    end

    assign serial_valid_o = sv_q;
    assign serial_data_o  = sd_q;
    assign frame_done_o   = fd_q;
    assign busy_o         = busy_q;
    assign grant_id_o     = gid_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Bench for serial_link_arbiter: a timing-level reference model predicts grants and
// frames, and a monitor reassembles the link and scores it against that model.
module tb_serial_link_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int G  = 1;
    localparam int IW = 2;
    localparam int EW = 32 + IW + W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            serial_valid, serial_data, frame_done, busy;
    logic [IW-1:0]   grant_id;
    logic [1:0]      state;

    serial_link_arbiter #(.width(W), .n_req(N), .gap(G)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .serial_valid_o(serial_valid), .serial_data_o(serial_data),
        .frame_done_o(frame_done), .busy_o(busy), .grant_id_o(grant_id), .state_o(state)
    );

    // Second instance with gap=0 and one requester held valid.
    logic            rst0_n;
    logic [N-1:0]    req_valid0;
    logic [N*W-1:0]  req_data0;
    logic [N-1:0]    req_ready0;
    logic            sv0, sd0, fd0, busy0;
    logic [IW-1:0]   gid0;
    logic [1:0]      state0;

    serial_link_arbiter #(.width(W), .n_req(N), .gap(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst0_n), .req_valid_i(req_valid0), .req_data_i(req_data0),
        .req_ready_o(req_ready0), .serial_valid_o(sv0), .serial_data_o(sd0),
        .frame_done_o(fd0), .busy_o(busy0), .grant_id_o(gid0), .state_o(state0)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model state: expected frames {start cycle, id, word}.
    logic [EW-1:0] exp_q[$];
    int            m_last;
    int            next_free;
    int            b_lo, b_hi;
    logic [N-1:0]  rv;
    logic [W-1:0]  words [N];

    task automatic model_reset();
        m_last    = N - 1;
        next_free = 0;
        b_lo      = 1;
        b_hi      = 0;
        exp_q.delete();
    endtask

    task automatic step(output int acc);
        int winner;
        logic [N-1:0] er;
        @(negedge clk);
        req_valid = rv;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
        #1;
        winner = -1;
        if (cyc >= next_free) begin
            for (int k = 1; k <= N; k++) begin
                if (winner < 0 && rv[(m_last + k) % N]) winner = (m_last + k) % N;
            end
        end
        er = '0;
        if (winner >= 0) er[winner] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        acc = winner;
        if (winner >= 0) begin
            exp_q.push_back({32'(cyc + 1), IW'(winner), words[winner]});
            m_last    = winner;
            b_lo      = cyc + 1;
            b_hi      = cyc + W + G;
            next_free = cyc + W + G + 1;
        end
    endtask

    // mode 0: drop valid on acceptance, 1: hold everything, 2: random traffic
    task automatic run(int n, int mode);
        int acc;
        for (int c = 0; c < n; c++) begin
            step(acc);
            for (int i = 0; i < N; i++) begin
                if (mode == 0 && i == acc) begin
                    rv[i] = 1'b0;
                end else if (mode == 2) begin
                    if (i == acc) begin
                        words[i] = W'($urandom);
                        rv[i]    = 1'($urandom_range(0, 1));
                    end else if (rv[i]) begin
                        if ($urandom_range(0, 7) == 0) rv[i] = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        rv[i]    = 1'b1;
                        words[i] = W'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic wait_idle();
        int acc;
        rv = '0;
        for (int i = 0; i < 40 && cyc < next_free; i++) step(acc);
    endtask

    task automatic grant_one(int who, logic [W-1:0] wd);
        int acc;
        acc = -1;
        rv[who]    = 1'b1;
        words[who] = wd;
        for (int i = 0; i < 20 && acc < 0; i++) step(acc);
        check("grant_one", 64'(acc), 64'(who));
        rv = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rv = '0;
        req_valid = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor for the main instance.
    int            bitpos = 0;
    int            start_c = 0;
    logic [W-1:0]  asm_w;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            bitpos = 0;
        end else begin
            check("busy", 64'(busy), 64'(cyc >= b_lo && cyc <= b_hi));
            if (serial_valid) begin
                if (bitpos == 0) start_c = cyc;
                asm_w[bitpos] = serial_data;
                check("frame_done", 64'(frame_done), 64'(bitpos == W - 1));
                bitpos++;
                if (bitpos == W) begin
                    bitpos = 0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_frame: got word %0h at cycle %0d, required no frame", asm_w, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (asm_w !== e[W-1:0] || grant_id !== e[W+IW-1:W] || start_c != int'(e[EW-1:W+IW])) begin
                            n_errors++;
                            $display("FAIL frame: got word %0h id %0d start %0d, required word %0h id %0d start %0d",
                                     asm_w, grant_id, start_c, e[W-1:0], e[W+IW-1:W], e[EW-1:W+IW]);
                        end
                    end
                end
            end else begin
                check("idle_data", 64'(serial_data), 64'd0);
                check("idle_done", 64'(frame_done), 64'd0);
                check("frame_cut", 64'(bitpos), 64'd0);
            end
        end
    end

    // Monitor for the gap=0 instance: exactly one idle link cycle between frames.
    int           idle_run0 = -1;
    int           bp0 = 0;
    logic [W-1:0] w0;

    always @(negedge clk) begin
        if (rst0_n) begin
            if (sv0) begin
                if (bp0 == 0 && idle_run0 >= 0) check("gap0_idle", 64'(idle_run0), 64'd1);
                w0[bp0] = sd0;
                check("gap0_done", 64'(fd0), 64'(bp0 == W - 1));
                bp0++;
                if (bp0 == W) begin
                    check("gap0_word", 64'(w0), 64'h3C);
                    check("gap0_grant", 64'(gid0), 64'd1);
                    bp0 = 0;
                    idle_run0 = 0;
                end
            end else if (idle_run0 >= 0) begin
                idle_run0++;
            end
        end
    end

    initial begin
        rst0_n     = 1'b0;
        req_valid0 = 4'b0010;
        req_data0  = 32'h0000_3C00;
        #22;
        rst0_n = 1'b1;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got no completion by 1ms, required bench to finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rv        = '0;
        for (int i = 0; i < N; i++) words[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_serial_valid", 64'(serial_valid), 64'd0);
        check("rst_serial_data", 64'(serial_data), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        #1;
        rst_n = 1'b1;

        // Single request 0xA5 from requester 0.
        rv       = 4'b0001;
        words[0] = 8'hA5;
        run(14, 0);

        // All four held valid: grants 0,1,2,3,0 every 10 cycles.
        do_reset();
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h04; words[3] = 8'h08;
        rv = 4'b1111;
        run(45, 1);
        // Fairness wrap: once 2 is granted only 0 and 3 remain; 3 must come first.
        acc = -1;
        for (int i = 0; i < 60 && acc != 2; i++) step(acc);
        check("wrap_setup", 64'(acc), 64'd2);
        rv = 4'b1001;
        run(25, 1);

        // Withdrawal in IDLE leaves the pointer alone.
        wait_idle();
        grant_one(3, 8'h5A);
        wait_idle();
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("ready_before_withdraw", 64'(req_ready), 64'b0010);
        req_valid = 4'b0000;
        #1;
        check("ready_after_withdraw", 64'(req_ready), 64'd0);
        rv = '0;
        run(2, 0);
        rv = 4'b1010;
        words[1] = 8'hC3; words[3] = 8'h3E;
        run(30, 0);

        // Reset during bit 3 of a frame from requester 2.
        wait_idle();
        grant_one(2, W'($urandom));
        run(3, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_serial_valid", 64'(serial_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_serial_data", 64'(serial_data), 64'd0);
        model_reset();
        rv = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        rv = 4'b1101;
        words[0] = W'($urandom); words[2] = W'($urandom); words[3] = W'($urandom);
        run(40, 0);

        // Random traffic.
        rv = '0;
        run(400, 2);

        // Drain outstanding frames.
        rv = '0;
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) step(acc);
        check("drain", 64'(exp_q.size()), 64'd0);
        run(3, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
